// File: rtl/sa8_sched_pkg.sv
// Shared types, defaults and helpers for the sa8 child scheduler.
// Optional hold timeout is enabled by defining SA8_SCHED_TIMEOUT_EN.
package sa8_sched_pkg;

    localparam int unsigned N_REQ_DEFAULT    = 5;
    localparam int unsigned HOLD_MAX_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } sched_state_e;

    // Wide enough for any supported requester count; callers truncate.
    function automatic logic [31:0] onehot_of(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/sa8_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Rotates req down by ptr, priority-encodes the lowest bit, then rotates the index back.
module sa8_rr_pick #(
    parameter int unsigned N_REQ = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [N_REQ-1:0] req_rot;
    logic [IDX_W:0]   rot_idx;
    logic [IDX_W-1:0] enc;
    logic [IDX_W:0]   sum;

    always_comb begin
        rot_idx = '0;
        req_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot_idx = (IDX_W+1)'(i) + {1'b0, ptr};
            if (rot_idx >= (IDX_W+1)'(N_REQ)) begin
                rot_idx = rot_idx - (IDX_W+1)'(N_REQ);
            end
            req_rot[i] = req[rot_idx[IDX_W-1:0]];
        end

        enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                enc = IDX_W'(i);
            end
        end

        sum = {1'b0, enc} + {1'b0, ptr};
        if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
        end

        winner = sum[IDX_W-1:0];
        valid  = |req;
    end

endmodule

// File: rtl/sa8_child_scheduler.sv
// Round-robin grant scheduler for the five level-8 sibling children.
// Define SA8_SCHED_TIMEOUT_EN to bound each grant to HOLD_MAX cycles.
module sa8_child_scheduler
    import sa8_sched_pkg::*;
#(
    parameter int unsigned  N_REQ    = N_REQ_DEFAULT,
    parameter int unsigned  HOLD_MAX = HOLD_MAX_DEFAULT,
    localparam int unsigned IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] done_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_id_o,
    output logic             busy_o,
    output logic             timeout_o
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
        $error("sa8_child_scheduler: HOLD_MAX must be in 2..255");
    end

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             released;
    logic             hold_expired;

    sa8_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_i),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

`ifdef SA8_SCHED_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    assign hold_expired = (state_q == StGrant) && (hold_cnt_q == 8'(HOLD_MAX - 1));

    // Cleared while idle so a fresh grant always starts counting from zero.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == StIdle) begin
            hold_cnt_d = '0;
        end else if (state_q == StGrant && hold_cnt_q != 8'(HOLD_MAX - 1)) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        released  = done_i[gnt_id_q] | ~req_i[gnt_id_q];

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d  = StGrant;
                    gnt_d    = N_REQ'(onehot_of(32'(pick_idx)));
                    gnt_id_d = pick_idx;
                    busy_d   = 1'b1;
                end
            end
            StGrant: begin
                if (released || hold_expired) begin
                    state_d   = StGap;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = (gnt_id_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_id_q + IDX_W'(1);
                    // A release on the final hold cycle is not a revocation.
                    timeout_d = hold_expired & ~released;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_sa8_child_scheduler.sv
// Directed self-checking bench for sa8_child_scheduler (N_REQ=5, HOLD_MAX=16).
// Timeout steps follow SA8_SCHED_TIMEOUT_EN; otherwise an unbounded hold is checked.
module tb_sa8_child_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req_i;
    logic [4:0] done_i;
    logic [4:0] gnt_o;
    logic [2:0] gnt_id_o;
    logic       busy_o;
    logic       timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_id;
    logic [4:0] exp_oh;

    always #5 clk = ~clk;

    sa8_child_scheduler #(
        .N_REQ    (5),
        .HOLD_MAX (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .gnt_id_o  (gnt_id_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [4:0] g, input logic [2:0] id,
                           input logic b);
        chk({tag, "_gnt"}, 32'(gnt_o), 32'(g));
        chk({tag, "_id"}, 32'(gnt_id_o), 32'(id));
        chk({tag, "_busy"}, 32'(busy_o), 32'(b));
    endtask

    task automatic chk_idle(input string tag, input logic to);
        chk({tag, "_gnt"}, 32'(gnt_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_o), 32'(to));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every child requesting.
        rst_n  = 1'b0;
        req_i  = 5'b11111;
        done_i = 5'b00000;
        tick();
        tick();
        chk_idle("reset", 1'b0);
        chk("reset_id", 32'(gnt_id_o), 32'd0);

        // Rotation 0,1,2,3,4,0 with a 3-cycle grant-to-grant period.
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            exp_id = 3'(k % 5);
            exp_oh = 5'b00001 << exp_id;
            chk_gnt("rot_grant", exp_oh, exp_id, 1'b1);
            done_i = exp_oh;
            tick();
            chk_idle("rot_gap", 1'b0);
            done_i = 5'b00000;
            tick();
            chk("rot_idle_gnt", 32'(gnt_o), 32'd0);
            tick();
        end
        chk_gnt("rot_next", 5'b00010, 3'd1, 1'b1);

        // Skip and wrap: ptr becomes 2, only children 1 and 4 request.
        done_i = 5'b00010;
        req_i  = 5'b10010;
        tick();
        done_i = 5'b00000;
        tick();
        tick();
        chk_gnt("skip_to_4", 5'b10000, 3'd4, 1'b1);
        done_i = 5'b10000;
        tick();
        done_i = 5'b00000;
        tick();
        tick();
        chk_gnt("wrap_to_1", 5'b00010, 3'd1, 1'b1);

        // Child 3 alone; done bits of other children are ignored.
        done_i = 5'b00010;
        req_i  = 5'b01000;
        tick();
        done_i = 5'b00000;
        tick();
        tick();
        chk_gnt("alone_3", 5'b01000, 3'd3, 1'b1);
        done_i = 5'b10111;
        tick();
        chk_gnt("ignore_other_done", 5'b01000, 3'd3, 1'b1);
        done_i = 5'b00000;

        // Withdraw: grant drops next cycle without timeout; ptr moves to 4.
        req_i = 5'b00000;
        tick();
        chk_idle("withdraw", 1'b0);
        req_i = 5'b11111;
        tick();
        tick();
        chk_gnt("ptr_after_withdraw", 5'b10000, 3'd4, 1'b1);

        // Hand the slot to child 2 (ptr becomes 0).
        done_i = 5'b10000;
        req_i  = 5'b00100;
        tick();
        done_i = 5'b00000;
        tick();
        tick();
        chk_gnt("hold_2", 5'b00100, 3'd2, 1'b1);

`ifdef SA8_SCHED_TIMEOUT_EN
        for (int i = 1; i < 16; i++) tick();
        chk_gnt("hold_last", 5'b00100, 3'd2, 1'b1);
        chk("hold_last_timeout", 32'(timeout_o), 32'd0);
        tick();
        chk_idle("timeout_fire", 1'b1);
        tick();
        chk("timeout_pulse_end", 32'(timeout_o), 32'd0);
        tick();
        chk_gnt("regrant_2", 5'b00100, 3'd2, 1'b1);
        for (int i = 1; i < 16; i++) tick();
        done_i = 5'b00100;
        tick();
        chk_idle("done_beats_timeout", 1'b0);
        done_i = 5'b00000;
`else
        for (int i = 0; i < 20; i++) tick();
        chk_gnt("unbounded_hold", 5'b00100, 3'd2, 1'b1);
        chk("unbounded_timeout", 32'(timeout_o), 32'd0);
        done_i = 5'b00100;
        tick();
        chk_idle("unbounded_release", 1'b0);
        done_i = 5'b00000;
`endif

        // Leave ptr at 1 with child 1 granted, then reset mid-grant.
        req_i = 5'b00001;
        tick();
        tick();
        chk_gnt("pre_rst_0", 5'b00001, 3'd0, 1'b1);
        done_i = 5'b00001;
        req_i  = 5'b00010;
        tick();
        done_i = 5'b00000;
        tick();
        tick();
        chk_gnt("pre_rst_1", 5'b00010, 3'd1, 1'b1);
        rst_n = 1'b0;
        req_i = 5'b00011;
        tick();
        chk_idle("mid_reset", 1'b0);
        chk("mid_reset_id", 32'(gnt_id_o), 32'd0);
        rst_n = 1'b1;
        tick();
        chk_gnt("post_rst_ptr0", 5'b00001, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
